proj_unit_param: RTL

//  Parametrised complex vector projection engine for the QR/Gram-Schmidt stage of the ZF detector.

---
 rtl/zf_fixed_pkg.sv | 29 ++
 rtl/seq_div_signed.sv | 90 +++++++++
 rtl/proj_unit_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/zf_fixed_pkg.sv
// Shared fixed-point definitions for the ZF detector datapath: default Q format,
// the projection FSM encoding and a saturating narrow helper.
package zf_fixed_pkg;

  localparam int unsigned DefW    = 16;
  localparam int unsigned DefFrac = 11;
  localparam int unsigned ONE     = 1 << DefFrac;
  localparam int unsigned MAXV    = (1 << (DefW - 1)) - 1;

  typedef enum logic [2:0] {
    StIdle,
    StDot,
    StDiv,
    StScale,
    StFin
  } state_e;

  // Clamp a sign-extended value into the w-bit two's complement range.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/seq_div_signed.sv
// Iterative signed restoring divider, one quotient bit per cycle (WQ cycles per divide).
// Quotient truncates toward zero and clamps symmetrically to +/-(2^(WQ-1)-1).
module seq_div_signed #(
  parameter int unsigned WN = 45,
  parameter int unsigned WD = 34,
  parameter int unsigned WQ = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [WN-1:0] dividend,
  input  logic signed [WD-1:0] divisor,
  output logic signed [WQ-1:0] quotient,
  output logic                 done,
  output logic                 div_zero,
  output logic                 ovf
);
  localparam int unsigned XW   = WN + WD + WQ;
  localparam int unsigned CntW = $clog2(WQ + 1);
  localparam logic [WQ-1:0] MaxQ = {1'b0, {(WQ - 1){1'b1}}};

  logic [WN-1:0]   dvd_abs;
  logic [WD-1:0]   dsr_abs;
  logic [XW-1:0]   rem_q, dsr_q, src_rem, src_dsr, rem_nx;
  logic            ge;
  logic [WQ-1:0]   mag_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q, neg_q, dz_q, pre_ovf_q, mag_ovf;

  // The start cycle already resolves the top quotient bit straight from the inputs.
  always_comb begin
    dvd_abs = dividend[WN-1] ? -dividend : dividend;
    dsr_abs = divisor[WD-1] ? -divisor : divisor;
    src_rem = busy_q ? rem_q : XW'(dvd_abs);
    src_dsr = busy_q ? dsr_q : (XW'(dsr_abs) << (WQ - 1));
    ge      = (src_rem >= src_dsr);
    rem_nx  = ge ? (src_rem - src_dsr) : src_rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      dsr_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      pre_ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q     <= rem_nx;
        dsr_q     <= src_dsr >> 1;
        mag_q     <= WQ'(ge);
        cnt_q     <= CntW'(WQ - 1);
        busy_q    <= 1'b1;
        neg_q     <= dividend[WN-1] ^ divisor[WD-1];
        dz_q      <= (divisor == '0);
        pre_ovf_q <= (XW'(dvd_abs) >= (XW'(dsr_abs) << WQ));
      end else if (busy_q) begin
        rem_q <= rem_nx;
        dsr_q <= dsr_q >> 1;
        mag_q <= {mag_q[WQ-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    mag_ovf = pre_ovf_q | mag_q[WQ-1];
    if (dz_q) begin
      quotient = '0;
    end else if (mag_ovf) begin
      quotient = neg_q ? -MaxQ : MaxQ;
    end else begin
      quotient = neg_q ? -mag_q : mag_q;
    end
  end

  assign ovf      = ~dz_q & mag_ovf;
  assign div_zero = dz_q;
  assign done     = done_q;

endmodule

// File: rtl/proj_unit_param.sv
// Complex vector projection proj_b(a) = (b^H a / b^H b) * b over N elements,
// sequenced DOT -> DIV -> SCALE -> FIN with a fixed 2N+W+1 cycle latency.
module proj_unit_param
  import zf_fixed_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned W    = DefW,
  parameter int unsigned FRAC = DefFrac
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*N*W-1:0] a_vec,
  input  logic [2*N*W-1:0] b_vec,
  output logic [2*N*W-1:0] proj_vec,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             sat
);
  localparam int unsigned AccW = 2 * W + $clog2(N) + 1;
  localparam int unsigned DvdW = AccW + FRAC;
  localparam int unsigned MulW = 2 * W + 2;
  localparam int unsigned CntW = $clog2((N > W ? N : W) + 1);
  localparam int unsigned VecW = 2 * N * W;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q;
  logic [VecW-1:0]        a_q, b_q, res_q, proj_q;
  logic signed [AccW-1:0] num_re_q, num_im_q, den_q;
  logic                   sat_acc_q, dz_q, sat_q, done_q;

  int unsigned            elem;
  logic signed [W-1:0]    a_re, a_im, b_re, b_im;
  logic signed [W:0]      mx_re, mx_im, my_re, my_im;
  logic signed [MulW-1:0] m_re, m_im, sq;
  logic signed [63:0]     s_re, s_im, c_re, c_im;
  logic                   p_sat;

  logic                   div_start;
  logic signed [DvdW-1:0] dvd_re, dvd_im;
  logic signed [W-1:0]    q_re, q_im;
  logic                   dre_done, dim_done, dre_dz, dim_dz, dre_ovf, dim_ovf;

  // One shared complex multiplier: conj(b_k)*a_k during DOT, q*b_k during SCALE.
  always_comb begin
    elem = (32'(cnt_q) < N) ? 32'(cnt_q) : 32'd0;
    a_re = a_q[2*elem*W +: W];
    a_im = a_q[(2*elem+1)*W +: W];
    b_re = b_q[2*elem*W +: W];
    b_im = b_q[(2*elem+1)*W +: W];
    if (state_q == StScale) begin
      mx_re = {q_re[W-1], q_re};
      mx_im = {q_im[W-1], q_im};
      my_re = {b_re[W-1], b_re};
      my_im = {b_im[W-1], b_im};
    end else begin
      mx_re = {b_re[W-1], b_re};
      mx_im = -{b_im[W-1], b_im};
      my_re = {a_re[W-1], a_re};
      my_im = {a_im[W-1], a_im};
    end
    m_re  = MulW'(mx_re) * MulW'(my_re) - MulW'(mx_im) * MulW'(my_im);
    m_im  = MulW'(mx_re) * MulW'(my_im) + MulW'(mx_im) * MulW'(my_re);
    sq    = MulW'(b_re) * MulW'(b_re) + MulW'(b_im) * MulW'(b_im);
    s_re  = 64'(m_re >>> FRAC);
    s_im  = 64'(m_im >>> FRAC);
    c_re  = sat_w(s_re, W);
    c_im  = sat_w(s_im, W);
    p_sat = (c_re != s_re) || (c_im != s_im);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start && !done_q) state_d = StDot;
      StDot:   if (cnt_q == CntW'(N - 1)) state_d = StDiv;
      StDiv:   if (cnt_q == CntW'(W - 1)) state_d = StScale;
      StScale: if (cnt_q == CntW'(N - 1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign div_start = (state_q == StDiv) && (cnt_q == '0);
  assign dvd_re    = DvdW'(num_re_q) <<< FRAC;
  assign dvd_im    = DvdW'(num_im_q) <<< FRAC;

  seq_div_signed #(.WN(DvdW), .WD(AccW), .WQ(W)) u_div_re (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dvd_re),
    .divisor  (den_q),
    .quotient (q_re),
    .done     (dre_done),
    .div_zero (dre_dz),
    .ovf      (dre_ovf)
  );

  seq_div_signed #(.WN(DvdW), .WD(AccW), .WQ(W)) u_div_im (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dvd_im),
    .divisor  (den_q),
    .quotient (q_im),
    .done     (dim_done),
    .div_zero (dim_dz),
    .ovf      (dim_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      proj_q    <= '0;
      num_re_q  <= '0;
      num_im_q  <= '0;
      den_q     <= '0;
      sat_acc_q <= 1'b0;
      dz_q      <= 1'b0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StFin);
      cnt_q   <= (state_d != state_q || state_q == StIdle) ? '0 : cnt_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (state_d == StDot) begin
            a_q       <= a_vec;
            b_q       <= b_vec;
            num_re_q  <= '0;
            num_im_q  <= '0;
            den_q     <= '0;
            sat_acc_q <= 1'b0;
          end
        end
        StDot: begin
          num_re_q <= num_re_q + AccW'(m_re);
          num_im_q <= num_im_q + AccW'(m_im);
          den_q    <= den_q + AccW'(sq);
        end
        StScale: begin
          res_q[2*elem*W +: W]     <= c_re[W-1:0];
          res_q[(2*elem+1)*W +: W] <= c_im[W-1:0];
          // Divider done lands on the first SCALE cycle; fold its clamp in then.
          sat_acc_q <= sat_acc_q | p_sat | ((dre_done | dim_done) & (dre_ovf | dim_ovf));
        end
        StFin: begin
          proj_q <= res_q;
          dz_q   <= dre_dz | dim_dz;
          sat_q  <= sat_acc_q;
        end
        default: ;
      endcase
    end
  end

  assign proj_vec = proj_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign sat      = sat_q;

endmodule
